shotclock_core: RTL and testbench



---
 rtl/shotclock_core.sv | 172 +++++++++++++++++
 tb/tb_shotclock_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shotclock_core.sv
// rtl/shotclock_core.sv - tenths-resolution shot-clock countdown with buzzer and display formatting
module shotclock_core #(
    parameter int DIGITS       = 2,
    parameter int FULL_SEC     = 24,
    parameter int SHORT_SEC    = 14,
    parameter int TENTHS_BELOW = 5,
    parameter int BUZZ_TENTHS  = 10,
    parameter int TICK_DIV     = 10000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_full,
    input  logic                  load_short,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   disp_sec,
    output logic [3:0]            disp_tenths,
    output logic                  show_tenths,
    output logic                  running,
    output logic                  expired,
    output logic                  buzzer
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
        logic [4*DIGITS-1:0] r;
        int v;
        v = n;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd_to_int(input logic [4*DIGITS-1:0] b);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--)
            r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // Zero digits above the units position are blanked until the first nonzero digit.
    function automatic logic [4*DIGITS-1:0] blank_lead(input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] r;
        logic lead;
        r = b;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && b[4*i +: 4] == 4'd0)
                r[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        return r;
    endfunction

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BUZZ_TENTHS > 1) ? $clog2(BUZZ_TENTHS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TENTHS - 1);
    localparam logic BUZZ_EN = (BUZZ_TENTHS > 0);
    localparam logic [4*DIGITS-1:0] FULL_BCD = to_bcd(FULL_SEC);
    localparam logic [4*DIGITS-1:0] SHORT_BCD = to_bcd(SHORT_SEC);
    localparam logic RESET_SHOW = (FULL_SEC < TENTHS_BELOW);

    typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_EXPIRED} state_t;

    state_t               state;
    logic [4*DIGITS-1:0]  sec_bcd;
    logic [3:0]           tenths;
    logic [PW-1:0]        presc;
    logic [BW-1:0]        buzz_cnt;
    logic [4*DIGITS-1:0]  dec_sec;
    logic [3:0]           dec_tenths;
    logic                 count_en;
    logic                 tick;
    logic                 last_tenth;
    logic                 is_zero;
    logic                 below;

    always_comb begin
        logic borrow;
        dec_sec    = sec_bcd;
        borrow     = (tenths == 4'd0);
        dec_tenths = borrow ? 4'd9 : tenths - 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (sec_bcd[4*i +: 4] == 4'd0) begin
                    dec_sec[4*i +: 4] = 4'd9;
                end else begin
                    dec_sec[4*i +: 4] = sec_bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign count_en   = (state == ST_RUN) || buzzer;
    assign tick       = count_en && (presc == PRESC_LAST);
    assign last_tenth = (sec_bcd == '0) && (tenths == 4'd1);
    assign is_zero    = (sec_bcd == '0) && (tenths == 4'd0);
    assign below      = (bcd_to_int(sec_bcd) < TENTHS_BELOW);
    assign running    = (state == ST_RUN);
    assign expired    = (state == ST_EXPIRED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_STOPPED;
            sec_bcd     <= FULL_BCD;
            tenths      <= 4'd0;
            presc       <= '0;
            buzz_cnt    <= '0;
            buzzer      <= 1'b0;
            disp_sec    <= blank_lead(FULL_BCD);
            show_tenths <= RESET_SHOW;
            disp_tenths <= RESET_SHOW ? 4'd0 : 4'hF;
        end else begin
            disp_sec    <= blank_lead(sec_bcd);
            show_tenths <= below;
            disp_tenths <= below ? tenths : 4'hF;

            if (count_en)
                presc <= tick ? '0 : presc + 1'b1;

            if (load_full || load_short) begin
                sec_bcd <= load_full ? FULL_BCD : SHORT_BCD;
                tenths  <= 4'd0;
                presc   <= '0;
                if (state == ST_EXPIRED) begin
                    state    <= ST_STOPPED;
                    buzzer   <= 1'b0;
                    buzz_cnt <= '0;
                end
            end else begin
                case (state)
                    ST_STOPPED: begin
                        if (start && !stop && !is_zero)
                            state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (tick) begin
                            sec_bcd <= dec_sec;
                            tenths  <= dec_tenths;
                        end
                        // Reaching 00.0 takes precedence over a coincident stop.
                        if (tick && last_tenth) begin
                            state    <= ST_EXPIRED;
                            buzzer   <= BUZZ_EN;
                            buzz_cnt <= '0;
                        end else if (stop) begin
                            state <= ST_STOPPED;
                        end
                    end
                    ST_EXPIRED: begin
                        if (buzzer && tick) begin
                            if (buzz_cnt == BUZZ_LAST) begin
                                buzzer   <= 1'b0;
                                buzz_cnt <= '0;
                            end else begin
                                buzz_cnt <= buzz_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_STOPPED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shotclock_core.sv
// tb/tb_shotclock_core.sv - directed bench for shotclock_core with a tenths-count reference model
module tb_shotclock_core;
    localparam int DIG  = 2;
    localparam int FULL = 24;
    localparam int SHRT = 14;
    localparam int TBLW = 5;
    localparam int BUZZ = 10;
    localparam int TD   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_full = 1'b0, load_short = 1'b0, start = 1'b0, stop = 1'b0;
    logic [4*DIG-1:0] disp_sec;
    logic [3:0] disp_tenths;
    logic show_tenths, running, expired, buzzer;

    shotclock_core #(
        .DIGITS(DIG), .FULL_SEC(FULL), .SHORT_SEC(SHRT),
        .TENTHS_BELOW(TBLW), .BUZZ_TENTHS(BUZZ), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_full(load_full), .load_short(load_short),
        .start(start), .stop(stop), .disp_sec(disp_sec), .disp_tenths(disp_tenths),
        .show_tenths(show_tenths), .running(running), .expired(expired), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Model: remaining time in tenths, tick phase, and buzzer time left in clock cycles.
    int m_val = FULL * 10;
    int m_phase = 0;
    logic m_run = 1'b0;
    logic m_exp = 1'b0;
    int m_buzz = 0;
    logic [4*DIG-1:0] e_dsec;
    logic [3:0] e_dten;
    logic e_show;

    function automatic logic [4*DIG-1:0] dsec_of(input int v);
        logic [4*DIG-1:0] r;
        logic lead;
        int s, p, d;
        s = v / 10;
        lead = 1'b1;
        for (int i = DIG - 1; i >= 0; i--) begin
            p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            d = (s / p) % 10;
            if (lead && d == 0 && i != 0) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = 4'(d);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic set_disp(input int v);
        e_show = (v / 10) < TBLW;
        e_dsec = dsec_of(v);
        e_dten = e_show ? 4'(v % 10) : 4'hF;
    endtask

    task automatic model_step(input logic rn, input logic lf, input logic ls, input logic st, input logic sp);
        logic cnt, tk;
        if (!rn) begin
            m_val = FULL * 10; m_phase = 0; m_run = 1'b0; m_exp = 1'b0; m_buzz = 0;
            set_disp(m_val);
        end else begin
            set_disp(m_val);
            cnt = m_run || (m_buzz > 0);
            tk  = cnt && (m_phase == TD - 1);
            if (cnt) m_phase = (m_phase + 1) % TD;
            if (lf || ls) begin
                m_val = (lf ? FULL : SHRT) * 10;
                m_phase = 0;
                if (m_exp) begin m_exp = 1'b0; m_buzz = 0; end
            end else if (m_run) begin
                if (tk) m_val = m_val - 1;
                if (tk && m_val == 0) begin
                    m_run = 1'b0; m_exp = 1'b1; m_buzz = BUZZ * TD;
                end else if (sp) begin
                    m_run = 1'b0;
                end
            end else if (m_exp) begin
                if (m_buzz > 0) m_buzz = m_buzz - 1;
            end else if (st && !sp && m_val != 0) begin
                m_run = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic rn, input logic lf, input logic ls, input logic st, input logic sp);
        rst_n = rn; load_full = lf; load_short = ls; start = st; stop = sp;
        @(posedge clk);
        #1;
        model_step(rn, lf, ls, st, sp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({running, expired, buzzer, show_tenths, disp_sec, disp_tenths} !==
                {m_run, m_exp, (m_buzz > 0), e_show, e_dsec, e_dten}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got run=%b exp=%b buz=%b show=%b sec=%h ten=%h expected run=%b exp=%b buz=%b show=%b sec=%h ten=%h",
                         $time, running, expired, buzzer, show_tenths, disp_sec, disp_tenths,
                         m_run, m_exp, (m_buzz > 0), e_show, e_dsec, e_dten);
            end
        end
    end

    initial begin
        int bcnt;
        logic found;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        idle(1);
        chk("rst_dsec", int'(disp_sec), 'h24);
        chk("rst_dten", int'(disp_tenths), 'hF);
        chk("rst_show", int'(show_tenths), 0);
        chk("rst_run", int'(running), 0);
        chk("rst_exp", int'(expired), 0);
        chk("rst_buz", int'(buzzer), 0);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_run", int'(running), 1);
        bcnt = 0;
        for (int k = 1; k <= 1100; k++) begin
            idle(1);
            if (k == 41) chk("dsec_23", int'(disp_sec), 'h23);
            if (k == 765) begin
                chk("dsec_f4", int'(disp_sec), 'hF4);
                chk("dten_9", int'(disp_tenths), 9);
                chk("show_49", int'(show_tenths), 1);
            end
            if (k == 960) begin
                chk("exp_at_960", int'(expired), 1);
                chk("run_at_960", int'(running), 0);
            end
            if (k == 961) begin
                chk("dsec_f0", int'(disp_sec), 'hF0);
                chk("dten_0", int'(disp_tenths), 0);
            end
            if (k >= 960 && buzzer) bcnt++;
        end
        chk("buzz_len", bcnt, 40);
        chk("exp_hold", int'(expired), 1);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_at_zero", int'(running), 0);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(365);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("pause_dsec", int'(disp_sec), 'hF4);
        chk("pause_dten", int'(disp_tenths), 9);
        idle(100);
        chk("pause_hold", int'(disp_tenths), 9);
        chk("pause_run", int'(running), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("resume_lag", int'(disp_tenths), 9);
        idle(1);
        chk("resume_dec", int'(disp_tenths), 8);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lshort_run", int'(running), 1);
        idle(1);
        chk("lshort_dsec", int'(disp_sec), 'h14);
        chk("lshort_dten", int'(disp_tenths), 'hF);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("lboth_dsec", int'(disp_sec), 'h24);
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            idle(1);
            if (expired) begin found = 1'b1; break; end
        end
        chk("expire_reached", int'(found), 1);
        idle(3);
        chk("buz_on", int'(buzzer), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lfull_buz", int'(buzzer), 0);
        chk("lfull_exp", int'(expired), 0);
        chk("lfull_run", int'(running), 0);
        idle(1);
        chk("lfull_dsec", int'(disp_sec), 'h24);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstrun_run", int'(running), 0);
        chk("rstrun_dsec", int'(disp_sec), 'h24);
        idle(1);
        chk("rst_start_ign", int'(running), 0);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            idle(1);
            if (expired) begin found = 1'b1; break; end
        end
        chk("expire2_reached", int'(found), 1);
        idle(5);
        chk("buz_on2", int'(buzzer), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstbuz_buz", int'(buzzer), 0);
        chk("rstbuz_exp", int'(expired), 0);
        chk("rstbuz_dsec", int'(disp_sec), 'h24);
        chk("rstbuz_dten", int'(disp_tenths), 'hF);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
